ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 127 ++++++++++++
 tb/tb_ahb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master AHB bus arbiter with address/data-phase muxing.
//
// Owner FSM: PARK (no requester, master 0 parked on the bus), OWN0, OWN1.
// Ownership only changes at an arbitration point. That is a ready edge where
// the current owner has dropped its request or is driving IDLE. In PARK, every
// ready edge is an arbitration point. Grants are decoded from registered state
// only. hwdata follows the data-phase owner, which trails the address-phase
// owner by one accepted transfer.
//
// Build option:
//   AHB_ARB_ROUND_ROBIN_EN - when defined, a simultaneous request goes to the
//                            master that did not own the bus last. When
//                            undefined, master 0 wins every tie.
module ahb_arbiter (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hbusreq0,
  input  logic        hbusreq1,
  input  logic [1:0]  htrans0,
  input  logic [1:0]  htrans1,
  input  logic [31:0] haddr0,
  input  logic [31:0] haddr1,
  input  logic        hwrite0,
  input  logic        hwrite1,
  input  logic [31:0] hwdata0,
  input  logic [31:0] hwdata1,
  input  logic        hreadyin0,
  input  logic        hreadyin1,
  input  logic        hreadyout,
  output logic        hgrant0,
  output logic        hgrant1,
  output logic        hmaster,
  output logic        hmaster_d,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  output logic        hreadyin
);

  localparam logic [1:0] ST_PARK    = 2'b00;
  localparam logic [1:0] ST_OWN0    = 2'b01;
  localparam logic [1:0] ST_OWN1    = 2'b10;
  localparam logic [1:0] TRANS_IDLE = 2'b00;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_lastm;
  logic       r_hmaster_d;
  logic       w_owner_req;
  logic       w_owner_idle;
  logic       w_arb_point;
  logic       w_tie_winner;

  // Current owner's request/transfer type, used to detect the arbitration point.
  always_comb begin
    if (r_state == ST_OWN1) begin
      w_owner_req  = hbusreq1;
      w_owner_idle = (htrans1 == TRANS_IDLE);
    end else begin
      w_owner_req  = hbusreq0;
      w_owner_idle = (htrans0 == TRANS_IDLE);
    end
    w_arb_point = hreadyout &&
                  ((r_state == ST_PARK) || !w_owner_req || w_owner_idle);
  end

  // Tie-break. The fixed-priority build still tracks lastm but ignores it.
`ifdef AHB_ARB_ROUND_ROBIN_EN
  assign w_tie_winner = ~r_lastm;
`else
  assign w_tie_winner = 1'b0 & r_lastm;
`endif

  // Next-state selection. Hold the state except at an arbitration point.
  always_comb begin
    // NOTE: default assignment first so every path drives w_next_state (no latch).
    w_next_state = r_state;
    if (r_state == 2'b11) begin
      w_next_state = ST_PARK;
    end else if (w_arb_point) begin
      case ({hbusreq1, hbusreq0})
        2'b01:   w_next_state = ST_OWN0;
        2'b10:   w_next_state = ST_OWN1;
        2'b11:   w_next_state = w_tie_winner ? ST_OWN1 : ST_OWN0;
        default: w_next_state = ST_PARK;
      endcase
    end
  end

  // Owner state, last-owner memory and data-phase owner.
  always_ff @(posedge hclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (hreset) begin
      r_state     <= ST_PARK;
      r_lastm     <= 1'b1;
      r_hmaster_d <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (hreadyout) begin
        r_hmaster_d <= hmaster;
      end
      if (w_arb_point && (w_next_state != ST_PARK)) begin
        r_lastm <= (w_next_state == ST_OWN1);
      end
    end
  end

  // Grants and owner indication, decoded purely from registered state.
  assign hgrant1   = (r_state == ST_OWN1);
  assign hgrant0   = ~hgrant1;
  assign hmaster   = (r_state == ST_OWN1);
  assign hmaster_d = r_hmaster_d;

  // Address-phase mux by hmaster. Data mux by the data-phase owner.
  always_comb begin
    htrans   = hmaster ? htrans1   : htrans0;
    haddr    = hmaster ? haddr1    : haddr0;
    hwrite   = hmaster ? hwrite1   : hwrite0;
    hreadyin = hmaster ? hreadyin1 : hreadyin0;
    hwdata   = r_hmaster_d ? hwdata1 : hwdata0;
    if (r_state == ST_PARK) begin
      htrans = TRANS_IDLE;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios plus randomized traffic. All outputs are
// compared every cycle against a behavioural owner model.
module tb_ahb_arbiter;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hbusreq0, hbusreq1;
  logic [1:0]  htrans0, htrans1;
  logic [31:0] haddr0, haddr1;
  logic        hwrite0, hwrite1;
  logic [31:0] hwdata0, hwdata1;
  logic        hreadyin0, hreadyin1;
  logic        hreadyout;
  logic        hgrant0, hgrant1, hmaster, hmaster_d;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hreadyin;

  ahb_arbiter dut (
    .hclk(hclk), .hreset(hreset),
    .hbusreq0(hbusreq0), .hbusreq1(hbusreq1),
    .htrans0(htrans0), .htrans1(htrans1),
    .haddr0(haddr0), .haddr1(haddr1),
    .hwrite0(hwrite0), .hwrite1(hwrite1),
    .hwdata0(hwdata0), .hwdata1(hwdata1),
    .hreadyin0(hreadyin0), .hreadyin1(hreadyin1),
    .hreadyout(hreadyout),
    .hgrant0(hgrant0), .hgrant1(hgrant1),
    .hmaster(hmaster), .hmaster_d(hmaster_d),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hreadyin(hreadyin)
  );

  always #5 hclk = ~hclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner as integer (-1 = parked), last owner, data owner.
  int m_own  = -1;
  int m_last = 1;
  int m_dm   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the arbitration rules to the inputs sampled at this rising edge.
  task automatic model_edge();
    bit       req [2];
    bit [1:0] tr  [2];
    bit       owner_done;
    int       nxt;
    req[0] = hbusreq0;
    req[1] = hbusreq1;
    tr[0]  = htrans0;
    tr[1]  = htrans1;
    if (hreset) begin
      m_own  = -1;
      m_dm   = 0;
      m_last = 1;
      return;
    end
    if (m_own < 0) owner_done = 1'b1;
    else           owner_done = !req[m_own] || (tr[m_own] == 2'b00);
    if (hreadyout) m_dm = (m_own == 1) ? 1 : 0;
    if (hreadyout && owner_done) begin
      if (req[0] && req[1]) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
        nxt = 1 - m_last;
`else
        nxt = 0;
`endif
      end else if (req[0]) nxt = 0;
      else if (req[1])     nxt = 1;
      else                 nxt = -1;
      m_own = nxt;
      if (nxt >= 0) m_last = nxt;
    end
  endtask

  task automatic check_outputs();
    bit sel;
    sel = (m_own == 1);
    check("hgrant0",   hgrant0,   32'(m_own != 1));
    check("hgrant1",   hgrant1,   32'(m_own == 1));
    check("hmaster",   hmaster,   32'(sel));
    check("hmaster_d", hmaster_d, 32'(m_dm));
    check("htrans",    htrans,    (m_own < 0) ? 32'd0 : 32'(sel ? htrans1 : htrans0));
    check("haddr",     haddr,     sel ? haddr1 : haddr0);
    check("hwrite",    hwrite,    32'(sel ? hwrite1 : hwrite0));
    check("hreadyin",  hreadyin,  32'(sel ? hreadyin1 : hreadyin0));
    check("hwdata",    hwdata,    (m_dm == 1) ? hwdata1 : hwdata0);
  endtask

  // One clock: update the model at the edge, then compare just after it.
  task automatic tick();
    @(posedge hclk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_bus(input bit r0, input bit r1, input bit [1:0] t0,
                         input bit [1:0] t1, input bit rdy);
    hbusreq0  = r0;
    hbusreq1  = r1;
    htrans0   = t0;
    htrans1   = t1;
    hreadyout = rdy;
  endtask

  initial begin
    hreset = 1'b1;
    set_bus(0, 0, 2'b00, 2'b00, 1);
    haddr0 = 32'h0000_1000; haddr1 = 32'h0000_2000;
    hwrite0 = 1'b0; hwrite1 = 1'b1;
    hwdata0 = 32'hA0A0_0000; hwdata1 = 32'hB1B1_0001;
    hreadyin0 = 1'b1; hreadyin1 = 1'b1;

    // Reset then idle.
    repeat (2) tick();
    hreset = 1'b0;
    repeat (2) tick();
    check("rst_hgrant0", hgrant0, 1);
    check("rst_hgrant1", hgrant1, 0);
    check("rst_htrans", htrans, 0);
    check("rst_hmaster", hmaster, 0);
    check("rst_hmaster_d", hmaster_d, 0);

    // Single master 1 from PARK.
    haddr1 = 32'h8100_0000; hwdata1 = 32'hD1D1_1234;
    set_bus(0, 1, 2'b00, 2'b10, 1);
    tick();
    check("m1_grant", hgrant1, 1);
    check("m1_haddr", haddr, 32'h8100_0000);
    tick();
    check("m1_hmaster_d", hmaster_d, 1);
    check("m1_hwdata", hwdata, 32'hD1D1_1234);
    set_bus(0, 0, 2'b00, 2'b00, 1);
    tick();

    // Burst protection: master 0 holds a 4-beat SEQ burst, master 1 joins at beat 2.
    haddr0 = 32'h8100_0000;
    set_bus(1, 0, 2'b00, 2'b00, 1);
    tick();
    check("burst_own0", hgrant0, 1);
    htrans0 = 2'b10;
    for (int b = 1; b < 4; b++) begin
      tick();
      haddr0  = 32'h8100_0000 + 32'(b);
      htrans0 = 2'b11;
      if (b == 2) begin
        hbusreq1 = 1'b1;
        htrans1  = 2'b10;
      end
    end
    tick();
    check("burst_hold", hgrant1, 0);
    check("burst_addr", haddr, 32'h8100_0003);
    set_bus(0, 1, 2'b00, 2'b10, 1);
    tick();
    check("burst_handover", hgrant1, 1);

    // Wait states at an arbitration point with both requesting.
    set_bus(1, 1, 2'b10, 2'b00, 0);
    repeat (3) begin
      tick();
      check("wait_hold", hmaster, 1);
    end
    hreadyout = 1'b1;
    tick();
    check("wait_release", hgrant0, 1);

    // Tie policy: both requesting, owners idle after single transfers.
    set_bus(1, 1, 2'b00, 2'b00, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef AHB_ARB_ROUND_ROBIN_EN
      check("tie_rr", hgrant1, 32'((i % 2) == 0));
`else
      check("tie_fixed", hgrant0, 1);
`endif
    end

    // Mid-burst reset during beat 3 of a master 1 burst.
    set_bus(0, 0, 2'b00, 2'b00, 1);
    tick();
    set_bus(0, 1, 2'b00, 2'b10, 1);
    tick();
    htrans1 = 2'b11;
    tick();
    hreset = 1'b1;
    tick();
    check("mrst_hgrant0", hgrant0, 1);
    check("mrst_htrans", htrans, 0);
    hreset = 1'b0;
    set_bus(1, 1, 2'b00, 2'b00, 1);
    tick();
    check("mrst_first_tie", hgrant0, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      hreset    = ($urandom_range(0, 99) == 0);
      hbusreq0  = $urandom_range(0, 1) == 1;
      hbusreq1  = $urandom_range(0, 1) == 1;
      htrans0   = 2'($urandom_range(0, 3));
      htrans1   = 2'($urandom_range(0, 3));
      haddr0    = $urandom;
      haddr1    = $urandom;
      hwrite0   = $urandom_range(0, 1) == 1;
      hwrite1   = $urandom_range(0, 1) == 1;
      hwdata0   = $urandom;
      hwdata1   = $urandom;
      hreadyin0 = $urandom_range(0, 1) == 1;
      hreadyin1 = $urandom_range(0, 1) == 1;
      hreadyout = $urandom_range(0, 3) != 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
